// File: rtl/axi_multiplexer.sv
// Packet-granular N:1 AXI4-Stream multiplexer with a one-beat registered output stage.
// Optional: define AXI_MUX_SELECT_LOOKAHEAD_EN to accept the next select on the tlast beat (no bubble).
module axi_multiplexer #(
  parameter  int NUM_STREAMS   = 2,
  parameter  int AXI_DATA_BITS = 32,
  localparam int SEL_BITS      = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
  localparam int KEEP_BITS     = AXI_DATA_BITS / 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [SEL_BITS-1:0]                        select_data,
  input  logic                                       select_valid,
  output logic                                       select_ready,
  input  logic [NUM_STREAMS-1:0][AXI_DATA_BITS-1:0]  in_tdata,
  input  logic [NUM_STREAMS-1:0][KEEP_BITS-1:0]      in_tkeep,
  input  logic [NUM_STREAMS-1:0]                     in_tlast,
  input  logic [NUM_STREAMS-1:0]                     in_tvalid,
  output logic [NUM_STREAMS-1:0]                     in_tready,
  output logic [AXI_DATA_BITS-1:0]                   out_tdata,
  output logic [KEEP_BITS-1:0]                       out_tkeep,
  output logic                                       out_tlast,
  output logic                                       out_tvalid,
  input  logic                                       out_tready
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state, state_nxt;
  logic [SEL_BITS-1:0]    sel_q, sel_nxt;
  logic                   out_valid_q;
  logic                   sel_ok, slot, load;
  logic [AXI_DATA_BITS-1:0] cur_tdata;
  logic [KEEP_BITS-1:0]   cur_tkeep;
  logic                   cur_tlast, cur_tvalid;

  assign sel_ok     = int'(select_data) < NUM_STREAMS;
  // Register can take a beat when empty or when its current beat drains this cycle.
  assign slot       = !out_valid_q || out_tready;
  assign out_tvalid = out_valid_q;

  always_comb begin
    cur_tdata  = '0;
    cur_tkeep  = '0;
    cur_tlast  = 1'b0;
    cur_tvalid = 1'b0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (sel_q == SEL_BITS'(i)) begin
        cur_tdata  = in_tdata[i];
        cur_tkeep  = in_tkeep[i];
        cur_tlast  = in_tlast[i];
        cur_tvalid = in_tvalid[i];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel_q;
    select_ready = 1'b0;
    in_tready    = '0;
    load         = 1'b0;
    case (state)
      IDLE: begin
        select_ready = 1'b1;
        if (select_valid && sel_ok) begin
          sel_nxt   = select_data;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
          if (sel_q == SEL_BITS'(i)) in_tready[i] = slot;
        end
        load = cur_tvalid && slot;
        if (load && cur_tlast) begin
`ifdef AXI_MUX_SELECT_LOOKAHEAD_EN
          select_ready = 1'b1;
          if (select_valid && sel_ok) sel_nxt   = select_data;
          else                        state_nxt = IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      select_ready = 1'b0;
      in_tready    = '0;
      load         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_tdata   <= '0;
      out_tkeep   <= '0;
      out_tlast   <= 1'b0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
      if (load) begin
        out_valid_q <= 1'b1;
        out_tdata   <= cur_tdata;
        out_tkeep   <= cur_tkeep;
        out_tlast   <= cur_tlast;
      end else if (out_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_multiplexer.sv
// Bench for axi_multiplexer: packet-level scoreboard plus a cycle model of the handshake rules.
module tb_axi_multiplexer;
  localparam int NS = 5;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int SB = 3;
`ifdef AXI_MUX_SELECT_LOOKAHEAD_EN
  localparam bit LA = 1'b1;
`else
  localparam bit LA = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [SB-1:0] select_data = '0;
  logic select_valid = 1'b0;
  logic select_ready;
  logic [NS-1:0][DW-1:0] in_tdata = '0;
  logic [NS-1:0][KW-1:0] in_tkeep = '0;
  logic [NS-1:0] in_tlast = '0;
  logic [NS-1:0] in_tvalid = '0;
  logic [NS-1:0] in_tready;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic out_tlast, out_tvalid;
  logic out_tready = 1'b0;

  int checks = 0;
  int failures = 0;

  beat_t src_q[NS][$];
  beat_t exp_q[$];
  int    sel_list[$];
  int    acc_cyc[$];
  int    out_cyc[$];
  bit    rdy_pat[$];
  int    active, sel_idx;
  bit    reg_full, hold_s;
  bit [NS-1:0] hold_v;

  axi_multiplexer #(.NUM_STREAMS(NS), .AXI_DATA_BITS(DW)) dut (
    .clk(clk), .rst(rst),
    .select_data(select_data), .select_valid(select_valid), .select_ready(select_ready),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete(); sel_list.delete(); rdy_pat.delete();
    active = -1; sel_idx = 0; reg_full = 1'b0; hold_s = 1'b0; hold_v = '0;
    select_valid = 1'b0; in_tvalid = '0;
  endtask

  // Queue one select; in-range selects also queue a packet on that stream and in the expected output.
  task automatic add_pkt(input int s, input int len, input logic [DW-1:0] base, input bit rnd);
    beat_t b;
    sel_list.push_back(s);
    if (s < NS) begin
      for (int k = 0; k < len; k++) begin
        b.data = rnd ? DW'($urandom) : base + DW'(k);
        b.keep = rnd ? KW'($urandom_range(0, 15)) : '1;
        b.last = (k == len - 1);
        src_q[s].push_back(b);
        exp_q.push_back(b);
      end
    end
  endtask

  // Cycle engine: drives sources/sink, checks DUT against model, advances model at each edge.
  task automatic run(input int vprob, input int rprob, input int stop_acc, input int budget);
    int c, n_acc, a;
    bit done, slot, acc, acc_last, e_srdy, shs, ohs;
    logic [NS-1:0] e_trdy;
    beat_t tmp;
    c = 0; n_acc = 0; done = 1'b0;
    acc_cyc.delete(); out_cyc.delete();
    while (!done) begin
      if (!hold_s) select_valid = (sel_idx < sel_list.size()) && ($urandom_range(0, 99) < vprob);
      if (sel_idx < sel_list.size()) select_data = SB'(sel_list[sel_idx]);
      for (int i = 0; i < NS; i++) begin
        if (!hold_v[i]) in_tvalid[i] = (src_q[i].size() > 0) && ($urandom_range(0, 99) < vprob);
        if (src_q[i].size() > 0) begin
          in_tdata[i] = src_q[i][0].data;
          in_tkeep[i] = src_q[i][0].keep;
          in_tlast[i] = src_q[i][0].last;
        end
      end
      out_tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : ($urandom_range(0, 99) < rprob);
      #1;
      a = active;
      slot = !reg_full || out_tready;
      e_trdy = '0; acc = 1'b0; acc_last = 1'b0;
      if (a >= 0) begin
        e_trdy[a] = slot;
        acc = in_tvalid[a] && slot;
        acc_last = acc && src_q[a][0].last;
      end
      e_srdy = (a < 0) || (LA && acc_last);
      shs = select_valid && e_srdy;
      ohs = reg_full && out_tready;
      checks++;
      if (in_tready !== e_trdy) begin
        failures++; $display("FAIL in_tready c=%0d got %b expected %b", c, in_tready, e_trdy);
      end
      checks++;
      if (select_ready !== e_srdy) begin
        failures++; $display("FAIL select_ready c=%0d got %b expected %b", c, select_ready, e_srdy);
      end
      checks++;
      if (out_tvalid !== reg_full) begin
        failures++; $display("FAIL out_tvalid c=%0d got %b expected %b", c, out_tvalid, reg_full);
      end
      if (reg_full && exp_q.size() > 0) begin
        checks++;
        if ({out_tdata, out_tkeep, out_tlast} !== exp_q[0]) begin
          failures++;
          $display("FAIL out_beat c=%0d got %h/%h/%b expected %h/%h/%b", c, out_tdata, out_tkeep,
                   out_tlast, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
        end
      end
      @(posedge clk); #1;
      if (ohs) begin tmp = exp_q.pop_front(); out_cyc.push_back(c); end
      for (int i = 0; i < NS; i++) hold_v[i] = in_tvalid[i] && !(acc && i == a);
      hold_s = select_valid && !shs;
      if (acc) begin
        tmp = src_q[a].pop_front(); acc_cyc.push_back(c); n_acc++; reg_full = 1'b1;
      end else if (out_tready) begin
        reg_full = 1'b0;
      end
      if (acc_last) active = -1;
      if (shs) begin
        if (sel_list[sel_idx] < NS) active = sel_list[sel_idx];
        sel_idx++;
      end
      c++;
      if (stop_acc > 0) done = (n_acc >= stop_acc);
      else done = (sel_idx >= sel_list.size()) && (exp_q.size() == 0) && !reg_full;
      if (!done && c >= budget) begin
        checks++; failures++; done = 1'b1;
        $display("FAIL timeout after %0d cycles, pending beats %0d expected 0", c, exp_q.size());
      end
    end
    select_valid = 1'b0; in_tvalid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; select_valid = 1'b1; select_data = '0;
    in_tvalid = '1; in_tlast = '0; in_tkeep = '1; out_tready = 1'b1;
    for (int i = 0; i < NS; i++) in_tdata[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (select_ready !== 1'b0) begin failures++; $display("FAIL rst_select_ready got %b expected 0", select_ready); end
    checks++;
    if (in_tready !== '0) begin failures++; $display("FAIL rst_in_tready got %b expected 0", in_tready); end
    checks++;
    if (out_tvalid !== 1'b0) begin failures++; $display("FAIL rst_out_tvalid got %b expected 0", out_tvalid); end
    checks++;
    if ({out_tdata, out_tkeep, out_tlast} !== '0) begin
      failures++; $display("FAIL rst_out_payload got %h/%h/%b expected 0", out_tdata, out_tkeep, out_tlast);
    end
    rst = 1'b0; select_valid = 1'b0; in_tvalid = '0;
    #1;
    checks++;
    if (select_ready !== 1'b1) begin failures++; $display("FAIL idle_select_ready got %b expected 1", select_ready); end
    clear_model();
  endtask

  task automatic test_single_packet();
    clear_model();
    add_pkt(1, 3, 32'hA0, 1'b0);
    run(100, 100, 0, 50);
    checks++;
    if (acc_cyc.size() != 3 || out_cyc.size() != 3) begin
      failures++; $display("FAIL t1_counts got %0d/%0d expected 3/3", acc_cyc.size(), out_cyc.size());
    end else begin
      checks++;
      if (acc_cyc[2] - acc_cyc[0] != 2) begin
        failures++; $display("FAIL t1_accept_span got %0d expected 2", acc_cyc[2] - acc_cyc[0]);
      end
      checks++;
      if (out_cyc[0] != acc_cyc[0] + 1 || out_cyc[2] - out_cyc[0] != 2) begin
        failures++; $display("FAIL t1_out_timing got %0d,%0d expected %0d,%0d", out_cyc[0], out_cyc[2],
                             acc_cyc[0] + 1, acc_cyc[0] + 3);
      end
    end
  endtask

  task automatic test_interleave();
    clear_model();
    add_pkt(0, 2, 32'h10, 1'b0);
    add_pkt(1, 2, 32'h20, 1'b0);
    add_pkt(0, 2, 32'h30, 1'b0);
    run(100, 100, 0, 60);
    checks++;
    if (out_cyc.size() != 6) begin failures++; $display("FAIL t2_out_count got %0d expected 6", out_cyc.size()); end
  endtask

  task automatic test_backpressure();
    clear_model();
    add_pkt(3, 4, 32'hB0, 1'b0);
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run(100, 100, 0, 60);
    checks++;
    if (out_cyc.size() != 4) begin failures++; $display("FAIL t3_out_count got %0d expected 4", out_cyc.size()); end
  endtask

  task automatic test_bad_select();
    clear_model();
    add_pkt(5, 0, '0, 1'b0);
    add_pkt(2, 3, 32'hD0, 1'b0);
    run(100, 100, 0, 60);
    checks++;
    if (out_cyc.size() != 3) begin failures++; $display("FAIL t4_out_count got %0d expected 3", out_cyc.size()); end
  endtask

  task automatic test_mid_reset();
    clear_model();
    add_pkt(2, 4, 32'h50, 1'b0);
    run(100, 100, 2, 50);
    rst = 1'b1; out_tready = 1'b0;
    in_tvalid[2] = 1'b1; in_tdata[2] = src_q[2][0].data; in_tlast[2] = 1'b0;
    #1;
    checks++;
    if (select_ready !== 1'b0 || in_tready !== '0) begin
      failures++; $display("FAIL t5_during_rst got %b/%b expected 0/0", select_ready, in_tready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_tvalid !== 1'b0 || out_tdata !== '0) begin
      failures++; $display("FAIL t5_out_after_rst got %b/%h expected 0/0", out_tvalid, out_tdata);
    end
    #1;
    checks++;
    if (select_ready !== 1'b1) begin failures++; $display("FAIL t5_idle_select_ready got %b expected 1", select_ready); end
    out_tready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (in_tready !== '0 || out_tvalid !== 1'b0) begin
        failures++; $display("FAIL t5_no_forward got %b/%b expected 0/0", in_tready, out_tvalid);
      end
    end
    clear_model();
  endtask

  task automatic test_lookahead();
    clear_model();
    add_pkt(0, 1, 32'hC0, 1'b0);
    add_pkt(3, 1, 32'hC3, 1'b0);
    run(100, 100, 0, 40);
    checks++;
    if (acc_cyc.size() != 2 || out_cyc.size() != 2) begin
      failures++; $display("FAIL t6_counts got %0d/%0d expected 2/2", acc_cyc.size(), out_cyc.size());
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != (LA ? 1 : 2)) begin
        failures++; $display("FAIL t6_accept_gap got %0d expected %0d", acc_cyc[1] - acc_cyc[0], LA ? 1 : 2);
      end
      checks++;
      if (out_cyc[1] - out_cyc[0] != (LA ? 1 : 2)) begin
        failures++; $display("FAIL t6_out_gap got %0d expected %0d", out_cyc[1] - out_cyc[0], LA ? 1 : 2);
      end
    end
  endtask

  task automatic test_random();
    clear_model();
    for (int p = 0; p < 30; p++) add_pkt(int'($urandom_range(0, 7)), int'($urandom_range(1, 4)), '0, 1'b1);
    run(60, 50, 0, 3000);
    clear_model();
    for (int p = 0; p < 30; p++) add_pkt(int'($urandom_range(0, 7)), int'($urandom_range(1, 4)), '0, 1'b1);
    run(100, 90, 0, 3000);
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_interleave();
    test_backpressure();
    test_bad_select();
    test_mid_reset();
    test_lookahead();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
